// File: rtl/rs_int_pkg.sv
// rs_int_pkg: shared types for the integer reservation station.
//   t_rs_alloc     : renamed uop offered by rename/alloc
//   t_uinstr_iss   : issue packet handed to the EX0 stage
//   t_prf_wr_pkt   : integer PRF write-back broadcast (wakeup)
//   RS_INT_ENTRIES : default station depth
//   lowestSet()    : priority-encode helper, isolates the lowest set bit
package rs_int_pkg;

    localparam int RS_INT_ENTRIES = 8;
    localparam int PRF_IDW        = 6;
    localparam int ROB_IDW        = 5;
    localparam int XLEN           = 32;

    typedef logic [PRF_IDW-1:0] t_prf_id;
    typedef logic [ROB_IDW-1:0] t_rob_id;
    typedef logic [XLEN-1:0]    t_xlen;

    typedef enum logic [1:0] {
        OP_REG  = 2'd0,
        OP_IMM  = 2'd1,
        OP_ZERO = 2'd2,
        OP_NONE = 2'd3
    } t_optype;

    typedef enum logic [3:0] {
        U_NOP  = 4'd0,
        U_ADD  = 4'd1,
        U_ADDI = 4'd2,
        U_SUB  = 4'd3,
        U_AND  = 4'd4,
        U_OR   = 4'd5
    } t_uop;

    typedef struct packed {
        t_uop        opcode;
        t_optype     src1_type;
        t_optype     src2_type;
        logic [15:0] imm;
    } t_uinstr;

    typedef struct packed {
        t_uinstr uinstr;
        t_rob_id robid;
        t_prf_id pdst;
        t_prf_id psrc1;
        t_prf_id psrc2;
        logic    src1_rdy;
        logic    src2_rdy;
        t_xlen   src1_val;
        t_xlen   src2_val;
    } t_rs_alloc;

    typedef struct packed {
        t_uinstr uinstr;
        t_rob_id robid;
        t_prf_id pdst;
        t_xlen   src1_val;
        t_xlen   src2_val;
    } t_uinstr_iss;

    typedef struct packed {
        t_prf_id pdst;
        t_xlen   data;
    } t_prf_wr_pkt;

    // Two's-complement trick: vec & -vec keeps only the lowest set bit.
    // Callers zero-extend their mask to 64 bits and truncate the result back.
    function automatic logic [63:0] lowestSet(input logic [63:0] vec);
        return vec & (~vec + 64'd1);
    endfunction

endpackage

// File: rtl/rs_int_if.sv
// rs_int_if: bundle between rename/write-back/flush sources and the RS.
//   master : drives alloc, wakeup, flush, stall; sees ready, issue, occupancy
//   slave  : the reservation station side
interface rs_int_if
    import rs_int_pkg::*;
#(
    parameter int NUM_ENTRIES = RS_INT_ENTRIES
) ();

    localparam int OCC_W = $clog2(NUM_ENTRIES) + 1;

    logic             alloc_valid;
    t_rs_alloc        alloc_pkt;
    logic             alloc_ready;
    logic             iprf_wr_en_ex1;
    t_prf_wr_pkt      iprf_wr_pkt_ex1;
    logic             br_mispred_rb1;
    logic             stall;
    logic             iss_ex0;
    t_uinstr_iss      iss_pkt_ex0;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output alloc_valid, alloc_pkt, iprf_wr_en_ex1, iprf_wr_pkt_ex1,
               br_mispred_rb1, stall,
        input  alloc_ready, iss_ex0, iss_pkt_ex0, occupancy
    );

    modport slave (
        input  alloc_valid, alloc_pkt, iprf_wr_en_ex1, iprf_wr_pkt_ex1,
               br_mispred_rb1, stall,
        output alloc_ready, iss_ex0, iss_pkt_ex0, occupancy
    );

endinterface

// File: rtl/rs_int_age_matrix.sv
// rs_int_age_matrix: relative-age tracker used when RS_AGE_SELECT_EN is defined.
//   clk, reset    : clock, asynchronous active-low reset
//   i_allocEn     : an entry is being written this cycle
//   i_allocOh     : onehot index of that entry
//   i_freeMask    : entries currently free (not valid)
//   i_candMask    : entries ready to issue
//   o_oldestOh    : onehot oldest candidate (zero when no candidate)
module rs_int_age_matrix #(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_allocEn,
    input  logic [NUM_ENTRIES-1:0] i_allocOh,
    input  logic [NUM_ENTRIES-1:0] i_freeMask,
    input  logic [NUM_ENTRIES-1:0] i_candMask,
    output logic [NUM_ENTRIES-1:0] o_oldestOh
);

    // r_older[i][j] = 1 means entry i was allocated before entry j.
    logic [NUM_ENTRIES-1:0] r_older [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_blocked;

    // A new entry is younger than everything valid: its own row is cleared
    // and its column is set in every valid row. Stale bits in free rows are
    // harmless because the row is rewritten when that slot is reallocated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_older[i] <= '0;
            end
        end else if (i_allocEn) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (i_allocOh[i]) begin
                    r_older[i] <= '0;
                end else if (!i_freeMask[i]) begin
                    r_older[i] <= r_older[i] | i_allocOh;
                end
            end
        end
    end

    // A candidate is the oldest when no other candidate is older than it.
    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (i_candMask[j] && r_older[j][i]) begin
                    w_blocked[i] = 1'b1;
                end
            end
        end
        o_oldestOh = i_candMask & ~w_blocked;
    end

endmodule

// File: rtl/rs_int.sv
// rs_int: data-capture reservation station for the integer pipe.
//   clk, reset : clock, asynchronous active-low reset
//   rsIf       : rs_int_if.slave - alloc handshake, PRF write-back wakeup,
//                flush, stall, issue packet to EX0 and occupancy count
// Build option: define RS_AGE_SELECT_EN to issue the oldest ready entry
// instead of the lowest-index ready entry.
module rs_int
    import rs_int_pkg::*;
#(
    parameter int NUM_ENTRIES = RS_INT_ENTRIES,
    parameter int ENTRY_IDW   = $clog2(NUM_ENTRIES)
) (
    input logic    clk,
    input logic    reset,
    rs_int_if.slave rsIf
);

    localparam int OCC_W = ENTRY_IDW + 1;

    t_rs_alloc              r_entry [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [OCC_W-1:0]       r_occupancy;

    logic [NUM_ENTRIES-1:0] w_free;
    logic [NUM_ENTRIES-1:0] w_allocOh;
    logic [NUM_ENTRIES-1:0] w_cand;
    logic [NUM_ENTRIES-1:0] w_selOh;
    logic                   w_allocReady;
    logic                   w_allocFire;
    logic                   w_issue;
    logic                   w_wbHit1;
    logic                   w_wbHit2;
    t_rs_alloc              w_allocEntry;
    t_uinstr_iss            w_issPkt;

    // Allocation only looks at registered state, so a slot freed by this
    // cycle's issue is not offered until the next cycle.
    assign w_free       = ~r_valid;
    assign w_allocOh    = NUM_ENTRIES'(lowestSet(64'(w_free)));
    assign w_allocReady = (r_occupancy != OCC_W'(NUM_ENTRIES));
    assign w_allocFire  = rsIf.alloc_valid & w_allocReady & ~rsIf.br_mispred_rb1;

    // Non-register sources are born ready with a zero value; register sources
    // catching a write-back in the allocation cycle take the broadcast data.
    assign w_wbHit1 = rsIf.iprf_wr_en_ex1 && !rsIf.alloc_pkt.src1_rdy &&
                      (rsIf.alloc_pkt.psrc1 == rsIf.iprf_wr_pkt_ex1.pdst);
    assign w_wbHit2 = rsIf.iprf_wr_en_ex1 && !rsIf.alloc_pkt.src2_rdy &&
                      (rsIf.alloc_pkt.psrc2 == rsIf.iprf_wr_pkt_ex1.pdst);

    always_comb begin
        w_allocEntry = rsIf.alloc_pkt;
        if (rsIf.alloc_pkt.uinstr.src1_type != OP_REG) begin
            w_allocEntry.src1_rdy = 1'b1;
            w_allocEntry.src1_val = '0;
        end else if (w_wbHit1) begin
            w_allocEntry.src1_rdy = 1'b1;
            w_allocEntry.src1_val = rsIf.iprf_wr_pkt_ex1.data;
        end
        if (rsIf.alloc_pkt.uinstr.src2_type != OP_REG) begin
            w_allocEntry.src2_rdy = 1'b1;
            w_allocEntry.src2_val = '0;
        end else if (w_wbHit2) begin
            w_allocEntry.src2_rdy = 1'b1;
            w_allocEntry.src2_val = rsIf.iprf_wr_pkt_ex1.data;
        end
    end

    always_comb begin
        w_cand = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_cand[i] = r_valid[i] & r_entry[i].src1_rdy & r_entry[i].src2_rdy;
        end
    end

`ifdef RS_AGE_SELECT_EN
    rs_int_age_matrix #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_ageMatrix (
        .clk       (clk),
        .reset     (reset),
        .i_allocEn (w_allocFire),
        .i_allocOh (w_allocOh),
        .i_freeMask(w_free),
        .i_candMask(w_cand),
        .o_oldestOh(w_selOh)
    );
`else
    assign w_selOh = NUM_ENTRIES'(lowestSet(64'(w_cand)));
`endif

    assign w_issue = (|w_cand) & ~rsIf.stall & ~rsIf.br_mispred_rb1;

    // The packet is forced to zero whenever nothing issues.
    always_comb begin
        w_issPkt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_issue && w_selOh[i]) begin
                w_issPkt.uinstr   = r_entry[i].uinstr;
                w_issPkt.robid    = r_entry[i].robid;
                w_issPkt.pdst     = r_entry[i].pdst;
                w_issPkt.src1_val = r_entry[i].src1_val;
                w_issPkt.src2_val = r_entry[i].src2_val;
            end
        end
    end

    // Payload needs no reset: it is only observed through a valid entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_allocFire && w_allocOh[i]) begin
                r_entry[i] <= w_allocEntry;
            end else if (r_valid[i] && rsIf.iprf_wr_en_ex1) begin
                if (!r_entry[i].src1_rdy && r_entry[i].psrc1 == rsIf.iprf_wr_pkt_ex1.pdst) begin
                    r_entry[i].src1_rdy <= 1'b1;
                    r_entry[i].src1_val <= rsIf.iprf_wr_pkt_ex1.data;
                end
                if (!r_entry[i].src2_rdy && r_entry[i].psrc2 == rsIf.iprf_wr_pkt_ex1.pdst) begin
                    r_entry[i].src2_rdy <= 1'b1;
                    r_entry[i].src2_val <= rsIf.iprf_wr_pkt_ex1.data;
                end
            end
        end
    end

    // Flush empties the station and wins over any same-cycle alloc.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= '0;
            r_occupancy <= '0;
        end else if (rsIf.br_mispred_rb1) begin
            r_valid     <= '0;
            r_occupancy <= '0;
        end else begin
            r_valid     <= (r_valid & ~(w_issue ? w_selOh : '0)) |
                           (w_allocFire ? w_allocOh : '0);
            r_occupancy <= r_occupancy + OCC_W'(w_allocFire) - OCC_W'(w_issue);
        end
    end

    assign rsIf.alloc_ready = w_allocReady;
    assign rsIf.iss_ex0     = w_issue;
    assign rsIf.iss_pkt_ex0 = w_issPkt;
    assign rsIf.occupancy   = r_occupancy;

`ifndef SYNTHESIS
    a_selOnehot: assert property (@(posedge clk) disable iff (!reset)
        w_issue |-> $onehot(w_selOh));
    a_selValid: assert property (@(posedge clk) disable iff (!reset)
        w_issue |-> |(w_selOh & r_valid));
    a_noOverflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_allocFire && !w_issue && r_occupancy == OCC_W'(NUM_ENTRIES)));
    a_noUnderflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_issue && !w_allocFire && r_occupancy == '0));
`endif

endmodule

// File: tb/tb_rs_int.sv
// tb_rs_int: scoreboard bench for rs_int. Expected issue packets are queued
// as uops are driven and compared whenever the station issues.
module tb_rs_int;
    import rs_int_pkg::*;

    localparam int N = RS_INT_ENTRIES;

    logic clk = 1'b0;
    logic reset;

    rs_int_if #(.NUM_ENTRIES(N)) rsBus ();

    rs_int #(.NUM_ENTRIES(N)) dut (
        .clk  (clk),
        .reset(reset),
        .rsIf (rsBus)
    );

    always #5 clk = ~clk;

    t_uinstr_iss expQ[$];
    t_uinstr_iss expPkt;
    int          checks = 0;
    int          passes = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    function automatic t_rs_alloc mkUop(input t_uop op, input int rob, input int pdst,
                                        input t_optype t1, input int ps1, input logic r1, input t_xlen v1,
                                        input t_optype t2, input int ps2, input logic r2, input t_xlen v2);
        t_rs_alloc u;
        u.uinstr.opcode    = op;
        u.uinstr.src1_type = t1;
        u.uinstr.src2_type = t2;
        u.uinstr.imm       = 16'(rob) + 16'h0100;
        u.robid            = t_rob_id'(rob);
        u.pdst             = t_prf_id'(pdst);
        u.psrc1            = t_prf_id'(ps1);
        u.psrc2            = t_prf_id'(ps2);
        u.src1_rdy         = r1;
        u.src2_rdy         = r2;
        u.src1_val         = v1;
        u.src2_val         = v2;
        return u;
    endfunction

    // Reference model of the issue packet: register sources carry the value
    // they should have captured, other source kinds read as zero.
    function automatic t_uinstr_iss expOf(input t_rs_alloc u, input t_xlen cap1, input t_xlen cap2);
        t_uinstr_iss e;
        e.uinstr   = u.uinstr;
        e.robid    = u.robid;
        e.pdst     = u.pdst;
        e.src1_val = (u.uinstr.src1_type == OP_REG) ? cap1 : '0;
        e.src2_val = (u.uinstr.src2_type == OP_REG) ? cap2 : '0;
        return e;
    endfunction

    // Drive one cycle of inputs just after the edge, return at the negedge
    // so the caller samples settled outputs for that cycle.
    task automatic applyStimulus(input logic av, input t_rs_alloc ap, input logic we,
                                 input int wpdst, input t_xlen wdata,
                                 input logic st, input logic fl);
        @(posedge clk);
        #1;
        rsBus.alloc_valid          = av;
        rsBus.alloc_pkt            = ap;
        rsBus.iprf_wr_en_ex1       = we;
        rsBus.iprf_wr_pkt_ex1.pdst = t_prf_id'(wpdst);
        rsBus.iprf_wr_pkt_ex1.data = wdata;
        rsBus.stall                = st;
        rsBus.br_mispred_rb1       = fl;
        @(negedge clk);
    endtask

    task automatic idle(input logic st);
        applyStimulus(1'b0, '0, 1'b0, 0, '0, st, 1'b0);
    endtask

    task automatic allocOnly(input t_rs_alloc u, input logic st);
        applyStimulus(1'b1, u, 1'b0, 0, '0, st, 1'b0);
    endtask

    task automatic wakeOnly(input int p, input t_xlen d);
        applyStimulus(1'b0, '0, 1'b1, p, d, 1'b0, 1'b0);
    endtask

    // Scoreboard: every issue must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsBus.iss_ex0) begin
            if (expQ.size() == 0) begin
                checkOutput("issUnexpected", 128'(rsBus.iss_ex0), 128'(0));
            end else begin
                expPkt = expQ.pop_front();
                checkOutput("issPkt", 128'(rsBus.iss_pkt_ex0), 128'(expPkt));
            end
        end
    end

    initial begin
        t_rs_alloc u;
        t_rs_alloc fa;
        t_rs_alloc fb;
        t_rs_alloc ua;
        t_rs_alloc ub;
        t_rs_alloc uc;

        reset                 = 1'b0;
        rsBus.alloc_valid     = 1'b0;
        rsBus.alloc_pkt       = '0;
        rsBus.iprf_wr_en_ex1  = 1'b0;
        rsBus.iprf_wr_pkt_ex1 = '0;
        rsBus.stall           = 1'b0;
        rsBus.br_mispred_rb1  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rstAllocReady", 128'(rsBus.alloc_ready), 128'(1));
        checkOutput("rstIss", 128'(rsBus.iss_ex0), 128'(0));
        checkOutput("rstOcc", 128'(rsBus.occupancy), 128'(0));
        checkOutput("rstPkt", 128'(rsBus.iss_pkt_ex0), 128'(0));
        @(posedge clk);
        #1 reset = 1'b1;

        // ADDI, src1 ready=5, immediate src2: issues the next cycle.
        u = mkUop(U_ADDI, 1, 10, OP_REG, 3, 1'b1, 32'd5, OP_IMM, 0, 1'b0, 32'hFFFF);
        expQ.push_back(expOf(u, 32'd5, 32'd0));
        allocOnly(u, 1'b0);
        checkOutput("t1NoEarly", 128'(rsBus.iss_ex0), 128'(0));
        idle(1'b0);
        checkOutput("t1Iss", 128'(rsBus.iss_ex0), 128'(1));
        checkOutput("t1Occ1", 128'(rsBus.occupancy), 128'(1));
        idle(1'b0);
        checkOutput("t1Occ0", 128'(rsBus.occupancy), 128'(0));
        checkOutput("t1IdlePkt", 128'(rsBus.iss_pkt_ex0), 128'(0));

        // ADD waiting on psrc2=12, woken three cycles after alloc.
        u = mkUop(U_ADD, 2, 13, OP_REG, 4, 1'b1, 32'd3, OP_REG, 12, 1'b0, 32'h0);
        expQ.push_back(expOf(u, 32'd3, 32'hABCD));
        allocOnly(u, 1'b0);
        checkOutput("t2Wait", 128'(rsBus.iss_ex0), 128'(0));
        for (int k = 0; k < 2; k++) begin
            idle(1'b0);
            checkOutput("t2Wait", 128'(rsBus.iss_ex0), 128'(0));
        end
        wakeOnly(12, 32'hABCD);
        checkOutput("t2NoSameCycle", 128'(rsBus.iss_ex0), 128'(0));
        idle(1'b0);
        checkOutput("t2Iss", 128'(rsBus.iss_ex0), 128'(1));
        idle(1'b0);

        // Alloc bypass: psrc1=7 catches the same-cycle write-back.
        u = mkUop(U_ADD, 3, 14, OP_REG, 7, 1'b0, 32'hDEAD, OP_ZERO, 0, 1'b0, 32'h0);
        expQ.push_back(expOf(u, 32'h11, 32'h0));
        applyStimulus(1'b1, u, 1'b1, 7, 32'h11, 1'b0, 1'b0);
        checkOutput("t3NoEarly", 128'(rsBus.iss_ex0), 128'(0));
        idle(1'b0);
        checkOutput("t3Iss", 128'(rsBus.iss_ex0), 128'(1));
        idle(1'b0);

        // Fill all entries with unready uops, then offer one more.
        for (int i = 0; i < N; i++) begin
            allocOnly(mkUop(U_SUB, 8 + i, 20 + i, OP_REG, 40 + i, 1'b0, '0, OP_IMM, 0, 1'b0, '0), 1'b0);
        end
        allocOnly(mkUop(U_OR, 30, 30, OP_REG, 1, 1'b1, 32'h77, OP_IMM, 0, 1'b0, '0), 1'b0);
        checkOutput("t4Full", 128'(rsBus.alloc_ready), 128'(0));
        checkOutput("t4Occ8", 128'(rsBus.occupancy), 128'(N));
        expQ.push_back(expOf(mkUop(U_SUB, 11, 23, OP_REG, 43, 1'b0, '0, OP_IMM, 0, 1'b0, '0), 32'h4343, '0));
        wakeOnly(43, 32'h4343);
        checkOutput("t4NoSameCycle", 128'(rsBus.iss_ex0), 128'(0));
        idle(1'b0);
        checkOutput("t4Iss", 128'(rsBus.iss_ex0), 128'(1));
        checkOutput("t4StillFull", 128'(rsBus.alloc_ready), 128'(0));
        idle(1'b0);
        checkOutput("t4Freed", 128'(rsBus.alloc_ready), 128'(1));
        checkOutput("t4Occ7", 128'(rsBus.occupancy), 128'(N - 1));
        for (int i = 0; i < N; i++) begin
            if (i != 3) begin
                expQ.push_back(expOf(mkUop(U_SUB, 8 + i, 20 + i, OP_REG, 40 + i, 1'b0, '0, OP_IMM, 0, 1'b0, '0),
                                     t_xlen'(32'h1000 + i), '0));
                wakeOnly(40 + i, t_xlen'(32'h1000 + i));
            end
        end
        idle(1'b0);
        idle(1'b0);
        checkOutput("t4Drained", 128'(rsBus.occupancy), 128'(0));

        // Ready entries landing in idx 2,0,1 through frees.
        fa = mkUop(U_ADD, 16, 32, OP_REG, 50, 1'b0, '0, OP_IMM, 0, 1'b0, '0);
        fb = mkUop(U_ADD, 17, 33, OP_REG, 51, 1'b0, '0, OP_IMM, 0, 1'b0, '0);
        ua = mkUop(U_AND, 18, 34, OP_REG, 1, 1'b1, 32'hA, OP_REG, 2, 1'b1, 32'hB);
        ub = mkUop(U_AND, 19, 35, OP_REG, 1, 1'b1, 32'hC, OP_REG, 2, 1'b1, 32'hD);
        uc = mkUop(U_OR, 20, 36, OP_REG, 1, 1'b1, 32'hE, OP_REG, 2, 1'b1, 32'hF);
        allocOnly(fa, 1'b1);
        allocOnly(fb, 1'b1);
        allocOnly(ua, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 50, 32'h50, 1'b1, 1'b0);
        checkOutput("t5Stall", 128'(rsBus.iss_ex0), 128'(0));
        applyStimulus(1'b0, '0, 1'b1, 51, 32'h51, 1'b1, 1'b0);
        checkOutput("t5Stall", 128'(rsBus.iss_ex0), 128'(0));
        expQ.push_back(expOf(fa, 32'h50, '0));
        expQ.push_back(expOf(fb, 32'h51, '0));
        idle(1'b0);
        idle(1'b0);
        allocOnly(ub, 1'b1);
        checkOutput("t5Stall", 128'(rsBus.iss_ex0), 128'(0));
        allocOnly(uc, 1'b1);
        checkOutput("t5Stall", 128'(rsBus.iss_ex0), 128'(0));
`ifdef RS_AGE_SELECT_EN
        expQ.push_back(expOf(ua, 32'hA, 32'hB));
        expQ.push_back(expOf(ub, 32'hC, 32'hD));
        expQ.push_back(expOf(uc, 32'hE, 32'hF));
`else
        expQ.push_back(expOf(ub, 32'hC, 32'hD));
        expQ.push_back(expOf(uc, 32'hE, 32'hF));
        expQ.push_back(expOf(ua, 32'hA, 32'hB));
`endif
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            checkOutput("t5Iss", 128'(rsBus.iss_ex0), 128'(1));
        end
        idle(1'b0);
        checkOutput("t5Occ0", 128'(rsBus.occupancy), 128'(0));

        // Stall two cycles, then flush with an alloc that must be dropped.
        allocOnly(mkUop(U_ADD, 21, 37, OP_REG, 60, 1'b0, '0, OP_IMM, 0, 1'b0, '0), 1'b0);
        allocOnly(mkUop(U_ADD, 22, 38, OP_REG, 1, 1'b1, 32'h22, OP_IMM, 0, 1'b0, '0), 1'b1);
        checkOutput("t6Stall", 128'(rsBus.iss_ex0), 128'(0));
        idle(1'b1);
        checkOutput("t6Stall", 128'(rsBus.iss_ex0), 128'(0));
        applyStimulus(1'b1, mkUop(U_ADD, 24, 39, OP_REG, 1, 1'b1, 32'h24, OP_IMM, 0, 1'b0, '0),
                      1'b0, 0, '0, 1'b0, 1'b1);
        checkOutput("t6FlushBlk", 128'(rsBus.iss_ex0), 128'(0));
        idle(1'b0);
        checkOutput("t6OccFlush", 128'(rsBus.occupancy), 128'(0));
        checkOutput("t6NoIss", 128'(rsBus.iss_ex0), 128'(0));
        wakeOnly(60, 32'h60);
        idle(1'b0);
        checkOutput("t6NoDropIss", 128'(rsBus.iss_ex0), 128'(0));

        // Asynchronous reset while a ready entry is issuing.
        allocOnly(mkUop(U_ADD, 25, 40, OP_REG, 1, 1'b1, 32'h25, OP_IMM, 0, 1'b0, '0), 1'b1);
        idle(1'b1);
        checkOutput("t7Occ1", 128'(rsBus.occupancy), 128'(1));
        @(posedge clk);
        #1 rsBus.stall = 1'b0;
        #1;
        checkOutput("t7PreRstIss", 128'(rsBus.iss_ex0), 128'(1));
        reset = 1'b0;
        #1;
        checkOutput("t7AsyncIss", 128'(rsBus.iss_ex0), 128'(0));
        checkOutput("t7AsyncOcc", 128'(rsBus.occupancy), 128'(0));
        checkOutput("t7AsyncPkt", 128'(rsBus.iss_pkt_ex0), 128'(0));
        @(posedge clk);
        #1 reset = 1'b1;
        idle(1'b0);
        idle(1'b0);
        checkOutput("t7PostRstIss", 128'(rsBus.iss_ex0), 128'(0));

        checkOutput("sbEmpty", 128'(expQ.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
